maze_game_ctrl: RTL and testbench

Top-level sequencer for the memory-maze game. Steps through menu, map preview, play, and win/lose outcomes, and counts down the map-preview window per difficulty. Validates every player move against the maze ROM through a shared, arbitrated read port. It drives the player position and state flags consumed by the VGA renderer.

---
 rtl/maze_pkg.sv | 44 ++++
 rtl/maze_game_ctrl_if.sv | 25 ++
 rtl/maze_move_checker.sv | 120 ++++++++++++
 rtl/maze_game_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_maze_game_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared encodings for the memory-maze game controller: top-level state and
// difficulty one-hot codes, move direction bit indices, checker sub-FSM states
// and the default maze geometry.
package maze_pkg;

    localparam int unsigned MAP_W_DEF = 30;
    localparam int unsigned MAP_H_DEF = 21;

    // Bit positions inside the move pulse vector
    localparam int unsigned DIR_UP    = 0;
    localparam int unsigned DIR_DOWN  = 1;
    localparam int unsigned DIR_LEFT  = 2;
    localparam int unsigned DIR_RIGHT = 3;

    localparam logic [1:0] LIVES_INIT = 2'd3;

    typedef enum logic [3:0] {
        StMenu = 4'b0001,
        StShow = 4'b0010,
        StPlay = 4'b0100,
        StDone = 4'b1000
    } game_state_e;

    typedef enum logic [2:0] {
        DiffEasy = 3'b001,
        DiffMed  = 3'b010,
        DiffHard = 3'b100
    } difficulty_e;

    typedef enum logic [1:0] {
        ChkIdle = 2'd0,
        ChkReq  = 2'd1,
        ChkWait = 2'd2
    } chk_state_e;

    function automatic difficulty_e next_difficulty(difficulty_e d);
        case (d)
            DiffEasy: return DiffMed;
            DiffMed:  return DiffHard;
            default:  return DiffEasy;
        endcase
    endfunction

endpackage

// File: rtl/maze_game_ctrl_if.sv
// Maze ROM read port shared through an external arbiter. The controller is the
// master; the arbiter/ROM side is the slave. Data returns one cycle after the
// cycle in which map_rd_req and map_rd_gnt are both high.
interface maze_game_ctrl_if #(
    parameter int unsigned MAP_W = maze_pkg::MAP_W_DEF
);
    logic             map_rd_req;
    logic             map_rd_gnt;
    logic [4:0]       map_addr;
    logic [MAP_W-1:0] map_data;

    modport master (
        output map_rd_req,
        output map_addr,
        input  map_rd_gnt,
        input  map_data
    );

    modport slave (
        input  map_rd_req,
        input  map_addr,
        output map_rd_gnt,
        output map_data
    );
endinterface

// File: rtl/maze_move_checker.sv
// PLAY-state move validator. Turns a move pulse into a target cell, reads the
// target row from the maze ROM via the arbitrated port and reports whether the
// target cell is open, a wall, or the goal column. Moves are dropped while a
// lookup is in flight.
module maze_move_checker
    import maze_pkg::*;
#(
    parameter int unsigned MAP_W  = MAP_W_DEF,
    parameter int unsigned MAP_H  = MAP_H_DEF,
    parameter int unsigned GOAL_X = 29
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [3:0]              move,
    input  logic [4:0]              cur_x,
    input  logic [4:0]              cur_y,
    maze_game_ctrl_if.master        rom,
    output logic                    res_open,
    output logic                    res_wall,
    output logic                    res_goal,
    output logic [4:0]              target_x,
    output logic [4:0]              target_y
);

    chk_state_e st_q, st_d;
    logic [4:0] tgt_x_q, tgt_x_d;
    logic [4:0] tgt_y_q, tgt_y_d;
    logic [4:0] addr_q, addr_d;
    logic       req_q, req_d;

    // One extra bit so that stepping left/up from 0 wraps to a large value and
    // fails the range test instead of aliasing a valid cell.
    logic [5:0] nx, ny;
    logic       in_range;
    logic       in_wait;
    logic       wall_bit;

    // Candidate target cell, direction priority up > down > left > right
    always_comb begin
        nx = {1'b0, cur_x};
        ny = {1'b0, cur_y};
        if (move[DIR_UP]) begin
            ny = ny - 6'd1;
        end else if (move[DIR_DOWN]) begin
            ny = ny + 6'd1;
        end else if (move[DIR_LEFT]) begin
            nx = nx - 6'd1;
        end else if (move[DIR_RIGHT]) begin
            nx = nx + 6'd1;
        end
    end

    assign in_range = (nx < 6'(MAP_W)) && (ny < 6'(MAP_H));

    // Sub-FSM state and handshake registers
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= ChkIdle;
            tgt_x_q <= 5'd0;
            tgt_y_q <= 5'd0;
            addr_q  <= 5'd0;
            req_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            tgt_x_q <= tgt_x_d;
            tgt_y_q <= tgt_y_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    // Next state: latch target, hold request until granted, then sample data
    always_comb begin
        st_d    = st_q;
        tgt_x_d = tgt_x_q;
        tgt_y_d = tgt_y_q;
        addr_d  = addr_q;
        req_d   = req_q;
        unique case (st_q)
            ChkIdle: begin
                if (enable && (|move) && in_range) begin
                    st_d    = ChkReq;
                    tgt_x_d = nx[4:0];
                    tgt_y_d = ny[4:0];
                    addr_d  = ny[4:0];
                    req_d   = 1'b1;
                end
            end
            ChkReq: begin
                if (!enable) begin
                    st_d  = ChkIdle;
                    req_d = 1'b0;
                end else if (rom.map_rd_gnt) begin
                    st_d  = ChkWait;
                    req_d = 1'b0;
                end
            end
            ChkWait: begin
                st_d = ChkIdle;
            end
            default: begin
                st_d  = ChkIdle;
                req_d = 1'b0;
            end
        endcase
    end

    assign rom.map_rd_req = req_q;
    assign rom.map_addr   = addr_q;

    assign in_wait  = (st_q == ChkWait) && enable;
    assign wall_bit = rom.map_data[tgt_x_q];
    assign res_wall = in_wait && wall_bit;
    assign res_open = in_wait && !wall_bit;
    assign res_goal = res_open && (tgt_x_q == 5'(GOAL_X));
    assign target_x = tgt_x_q;
    assign target_y = tgt_y_q;

endmodule

// File: rtl/maze_game_ctrl.sv
// Top-level sequencer for the memory-maze game: MENU -> SHOW (timed map
// preview) -> PLAY -> DONE (win/loss). Move validation is delegated to
// maze_move_checker; this block owns position, difficulty, lives and flags.
// Optional feature macro: MAZE_LIVES_EN (three lives, wall hit respawns the
// player); when undefined any wall hit ends the game and lives reads 0.
module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int unsigned MAP_W     = MAP_W_DEF,
    parameter int unsigned MAP_H     = MAP_H_DEF,
    parameter int unsigned START_X   = 0,
    parameter int unsigned START_Y   = 11,
    parameter int unsigned GOAL_X    = 29,
    parameter int unsigned SHOW_EASY = 50_000_000,
    parameter int unsigned SHOW_MED  = 25_000_000,
    parameter int unsigned SHOW_HARD = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         move,
    input  logic               start,
    input  logic               select,
    maze_game_ctrl_if.master   rom,
    output logic [4:0]         player_x,
    output logic [4:0]         player_y,
    output logic [3:0]         state,
    output logic               won,
    output logic [2:0]         difficulty,
    output logic               map_visible,
    output logic [1:0]         lives
);

    game_state_e state_q, state_d;
    difficulty_e diff_q, diff_d;
    logic        won_q, won_d;
    logic [4:0]  px_q, px_d;
    logic [4:0]  py_q, py_d;
    logic [31:0] cnt_q, cnt_d;
    logic        vis_q, vis_d;

    logic        res_open, res_wall, res_goal;
    logic [4:0]  target_x, target_y;

`ifdef MAZE_LIVES_EN
    logic [1:0]  lives_q, lives_d;
`endif

    function automatic logic [31:0] show_cycles(difficulty_e d);
        case (d)
            DiffMed:  return 32'(SHOW_MED);
            DiffHard: return 32'(SHOW_HARD);
            default:  return 32'(SHOW_EASY);
        endcase
    endfunction

    maze_move_checker #(
        .MAP_W  (MAP_W),
        .MAP_H  (MAP_H),
        .GOAL_X (GOAL_X)
    ) u_checker (
        .clk      (clk),
        .reset    (reset),
        .enable   (state_q == StPlay),
        .move     (move),
        .cur_x    (px_q),
        .cur_y    (py_q),
        .rom      (rom),
        .res_open (res_open),
        .res_wall (res_wall),
        .res_goal (res_goal),
        .target_x (target_x),
        .target_y (target_y)
    );

    // Game state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StMenu;
            diff_q  <= DiffEasy;
            won_q   <= 1'b0;
            px_q    <= 5'(START_X);
            py_q    <= 5'(START_Y);
            cnt_q   <= 32'd0;
            vis_q   <= 1'b0;
`ifdef MAZE_LIVES_EN
            lives_q <= LIVES_INIT;
`endif
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
            won_q   <= won_d;
            px_q    <= px_d;
            py_q    <= py_d;
            cnt_q   <= cnt_d;
            vis_q   <= vis_d;
`ifdef MAZE_LIVES_EN
            lives_q <= lives_d;
`endif
        end
    end

    // Top FSM next state, preview countdown and move-result handling
    always_comb begin
        state_d = state_q;
        diff_d  = diff_q;
        won_d   = won_q;
        px_d    = px_q;
        py_d    = py_q;
        cnt_d   = cnt_q;
`ifdef MAZE_LIVES_EN
        lives_d = lives_q;
`endif
        unique case (state_q)
            StMenu: begin
                if (start) begin
                    cnt_d   = show_cycles(diff_q);
                    px_d    = 5'(START_X);
                    py_d    = 5'(START_Y);
                    won_d   = 1'b0;
                    state_d = StShow;
`ifdef MAZE_LIVES_EN
                    lives_d = LIVES_INIT;
`endif
                end else if (select) begin
                    diff_d = next_difficulty(diff_q);
                end
            end
            StShow: begin
                // Counter holds the cycles left including this one
                if (start || (cnt_q <= 32'd1)) begin
                    state_d = StPlay;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StPlay: begin
                if (res_open) begin
                    px_d = target_x;
                    py_d = target_y;
                    if (res_goal) begin
                        won_d   = 1'b1;
                        state_d = StDone;
                    end
                end else if (res_wall) begin
`ifdef MAZE_LIVES_EN
                    if (lives_q == 2'd1) begin
                        lives_d = 2'd0;
                        won_d   = 1'b0;
                        state_d = StDone;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        px_d    = 5'(START_X);
                        py_d    = 5'(START_Y);
                    end
`else
                    won_d   = 1'b0;
                    state_d = StDone;
`endif
                end
            end
            StDone: begin
                if (start) begin
                    state_d = StMenu;
                end
            end
            default: begin
                state_d = StMenu;
            end
        endcase
        vis_d = (state_d == StShow) || (state_d == StDone);
    end

    assign state       = state_q;
    assign difficulty  = diff_q;
    assign won         = won_q;
    assign player_x    = px_q;
    assign player_y    = py_q;
    assign map_visible = vis_q;
`ifdef MAZE_LIVES_EN
    assign lives       = lives_q;
`else
    assign lives       = 2'd0;
`endif

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Self-checking bench for maze_game_ctrl. A cycle-level behavioural model of
// the game rules runs alongside the DUT and is compared on every falling edge;
// a directed sequence pins key values with literal expectations, followed by
// randomized play against a randomized maze.
module tb_maze_game_ctrl;

    localparam int MAP_W     = 30;
    localparam int MAP_H     = 21;
    localparam int START_X   = 0;
    localparam int START_Y   = 11;
    localparam int GOAL_X    = 29;
    localparam int SHOW_EASY = 20;
    localparam int SHOW_MED  = 15;
    localparam int SHOW_HARD = 10;
`ifdef MAZE_LIVES_EN
    localparam int LIV = 3;
`else
    localparam int LIV = 0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] move;
    logic       start;
    logic       select;
    logic       gnt;
    logic [4:0] player_x, player_y;
    logic [3:0] state;
    logic       won;
    logic [2:0] difficulty;
    logic       map_visible;
    logic [1:0] lives;

    logic [MAP_W-1:0] maze [MAP_H];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    maze_game_ctrl_if #(.MAP_W(MAP_W)) rom ();

    maze_game_ctrl #(
        .MAP_W     (MAP_W),
        .MAP_H     (MAP_H),
        .START_X   (START_X),
        .START_Y   (START_Y),
        .GOAL_X    (GOAL_X),
        .SHOW_EASY (SHOW_EASY),
        .SHOW_MED  (SHOW_MED),
        .SHOW_HARD (SHOW_HARD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .move        (move),
        .start       (start),
        .select      (select),
        .rom         (rom),
        .player_x    (player_x),
        .player_y    (player_y),
        .state       (state),
        .won         (won),
        .difficulty  (difficulty),
        .map_visible (map_visible),
        .lives       (lives)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom.map_rd_gnt = gnt;

    // ROM behind the arbiter: row data one cycle after acceptance, junk otherwise
    always @(posedge clk) begin
        if (rom.map_rd_req && rom.map_rd_gnt && (int'(rom.map_addr) < MAP_H))
            rom.map_data <= maze[rom.map_addr];
        else
            rom.map_data <= MAP_W'($urandom);
    end

    // ---------------- behavioural model ----------------
    // m_state: 0 menu, 1 show, 2 play, 3 done; m_diff: 0 easy, 1 med, 2 hard
    // m_phase: 0 no lookup, 1 waiting for grant, 2 data arriving
    int m_state, m_diff, m_x, m_y, m_won, m_lives, m_cnt, m_phase, m_tx, m_ty, m_addr;

    function automatic int show_len(int d);
        return (d == 0) ? SHOW_EASY : (d == 1) ? SHOW_MED : SHOW_HARD;
    endfunction

    always @(posedge clk) begin
        int tx, ty;
        if (reset) begin
            m_state = 0; m_diff = 0; m_x = START_X; m_y = START_Y; m_won = 0;
            m_lives = LIV; m_cnt = 0; m_phase = 0; m_addr = 0;
        end else begin
            case (m_state)
                0: begin
                    if (start) begin
                        m_cnt = show_len(m_diff); m_x = START_X; m_y = START_Y;
                        m_lives = LIV; m_won = 0; m_state = 1;
                    end else if (select) begin
                        m_diff = (m_diff + 1) % 3;
                    end
                end
                1: begin
                    if (start || m_cnt <= 1) m_state = 2;
                    else m_cnt = m_cnt - 1;
                end
                2: begin
                    if (m_phase == 0) begin
                        if (move != 4'd0) begin
                            tx = m_x; ty = m_y;
                            if (move[0]) ty = ty - 1;
                            else if (move[1]) ty = ty + 1;
                            else if (move[2]) tx = tx - 1;
                            else tx = tx + 1;
                            if (tx >= 0 && tx < MAP_W && ty >= 0 && ty < MAP_H) begin
                                m_tx = tx; m_ty = ty; m_addr = ty; m_phase = 1;
                            end
                        end
                    end else if (m_phase == 1) begin
                        if (gnt) m_phase = 2;
                    end else begin
                        m_phase = 0;
                        if (!maze[m_ty][m_tx]) begin
                            m_x = m_tx; m_y = m_ty;
                            if (m_tx == GOAL_X) begin m_state = 3; m_won = 1; end
                        end else if (LIV == 0 || m_lives == 1) begin
                            m_lives = 0; m_won = 0; m_state = 3;
                        end else begin
                            m_lives = m_lives - 1; m_x = START_X; m_y = START_Y;
                        end
                    end
                end
                default: begin
                    if (start) m_state = 0;
                end
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model away from the clock edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(state), 1 << m_state);
            chk("difficulty", int'(difficulty), 1 << m_diff);
            chk("player_x", int'(player_x), m_x);
            chk("player_y", int'(player_y), m_y);
            chk("won", int'(won), m_won);
            chk("lives", int'(lives), m_lives);
            chk("map_visible", int'(map_visible), int'(m_state == 1 || m_state == 3));
            chk("map_rd_req", int'(rom.map_rd_req), int'(m_state == 2 && m_phase == 1));
            if (m_state == 2 && m_phase == 1) chk("map_addr", int'(rom.map_addr), m_addr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_move(input logic [3:0] m);
        move = m; tick(); move = 4'd0; tick(); tick();
    endtask

    initial begin
        reset = 1'b1; move = 4'd0; start = 1'b0; select = 1'b0; gnt = 1'b1;
        for (int r = 0; r < MAP_H; r++) maze[r] = '0;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1;
        chk("rst_state", int'(state), 1);
        chk("rst_diff", int'(difficulty), 1);
        chk("rst_pos", int'({player_x, player_y}), (START_X << 5) | START_Y);
        chk("rst_req", int'(rom.map_rd_req), 0);
        chk("rst_addr", int'(rom.map_addr), 0);
        chk("rst_lives", int'(lives), LIV);

        // Difficulty rotation and preview length on hard
        select = 1'b1; tick(); select = 1'b0; tick();
        select = 1'b1; tick(); select = 1'b0;
        chk("diff_hard", int'(difficulty), 4);
        pulse_start();
        chk("show_state", int'(state), 2);
        chk("show_vis", int'(map_visible), 1);
        for (int i = 0; i < 9; i++) tick();
        chk("show_last", int'(state), 2);
        tick();
        chk("play_at_11", int'(state), 4);

        // Open move right with immediate grant
        move = 4'b1000; tick(); move = 4'd0;
        chk("req_up", int'(rom.map_rd_req), 1);
        chk("req_addr", int'(rom.map_addr), 11);
        tick();
        chk("req_drop", int'(rom.map_rd_req), 0);
        chk("x_before", int'(player_x), 0);
        tick();
        chk("x_after", int'(player_x), 1);

        // Left back to 0, then left out of range, then up beats left/down
        do_move(4'b0100);
        chk("x_left", int'(player_x), 0);
        move = 4'b0100; tick(); move = 4'd0;
        chk("oob_noreq", int'(rom.map_rd_req), 0);
        tick(); tick();
        chk("oob_x", int'(player_x), 0);
        do_move(4'b0011);
        chk("up_prio", int'(player_y), 10);
        do_move(4'b0010);
        chk("down_y", int'(player_y), 11);

        // Grant held low 5 cycles, extra moves ignored meanwhile
        gnt = 1'b0;
        move = 4'b1000; tick(); move = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            chk("hold_req", int'(rom.map_rd_req), 1);
            chk("hold_addr", int'(rom.map_addr), 11);
            tick();
        end
        move = 4'd0; gnt = 1'b1;
        chk("hold_req5", int'(rom.map_rd_req), 1);
        tick();
        chk("late_x0", int'(player_x), 0);
        tick();
        chk("late_x1", int'(player_x), 1);
        chk("late_y", int'(player_y), 11);
        tick();

        // Wall hits
        maze[11][2] = 1'b1;
`ifdef MAZE_LIVES_EN
        for (int h = 0; h < 3; h++) begin
            if (h > 0) do_move(4'b1000);
            do_move(4'b1000);
            if (h < 2) begin
                chk("hit_lives", int'(lives), 2 - h);
                chk("hit_x", int'(player_x), START_X);
                chk("hit_state", int'(state), 4);
            end
        end
        chk("dead_lives", int'(lives), 0);
`else
        do_move(4'b1000);
`endif
        chk("lose_state", int'(state), 8);
        chk("lose_won", int'(won), 0);
        pulse_start();
        chk("menu_again", int'(state), 1);
        chk("diff_kept", int'(difficulty), 4);

        // Walk to the goal column
        maze[11][2] = 1'b0;
        pulse_start(); pulse_start();
        chk("skip_show", int'(state), 4);
        for (int i = 0; i < GOAL_X; i++) do_move(4'b1000);
        chk("win_state", int'(state), 8);
        chk("win_won", int'(won), 1);
        chk("win_vis", int'(map_visible), 1);
        chk("win_x", int'(player_x), GOAL_X);
        pulse_start();
        chk("win_menu", int'(state), 1);

        // Reset while data is in flight
        pulse_start(); pulse_start();
        move = 4'b1000; tick(); move = 4'd0; tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rstw_state", int'(state), 1);
        chk("rstw_req", int'(rom.map_rd_req), 0);
        chk("rstw_x", int'(player_x), START_X);
        tick();
        chk("rstw_x2", int'(player_x), START_X);

        // Randomized play
        for (int c = 0; c < 6000; c++) begin
            if (m_state == 0) begin
                for (int r = 0; r < MAP_H; r++)
                    for (int x = 0; x < MAP_W; x++)
                        maze[r][x] = ($urandom_range(0, 5) == 0);
            end
            reset  = ($urandom_range(0, 299) == 0);
            case (m_state)
                0: start = ($urandom_range(0, 9) == 0);
                1: start = ($urandom_range(0, 15) == 0);
                2: start = ($urandom_range(0, 19) == 0);
                default: start = ($urandom_range(0, 4) == 0);
            endcase
            select = ($urandom_range(0, 5) == 0);
            gnt    = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0)
                move = 4'd0;
            else if ($urandom_range(0, 1) == 0)
                move = 4'b1000;
            else
                move = 4'($urandom_range(1, 15));
            tick();
        end
        reset = 1'b0; start = 1'b0; select = 1'b0; move = 4'd0; gnt = 1'b1;
        tick();
        chk_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
